// File: rtl/cmac_usplus_collector.sv
// CMAC RX collector: store-and-forward frame buffer with commit/rewind
// on the write side and a skid-buffered replay stream on the read side.
module cmac_usplus_collector #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_AW     = 5,
  parameter int MAX_BYTES  = 9600
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] din_data,
  input  logic         din_valid,
  input  logic         din_sop,
  input  logic         din_eop,
  input  logic [7:0]   din_mty,
  input  logic         din_err,
  output logic [511:0] dout_data,
  output logic         dout_valid,
  output logic         dout_sop,
  output logic         dout_eop,
  output logic [7:0]   dout_mty,
  output logic [13:0]  dout_bytes,
  input  logic         dout_ready,
  output logic [31:0]  frame_count,
  output logic [31:0]  drop_count
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wst_t;
  typedef enum logic {R_IDLE, R_SEND} rst_t;
  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [7:0]   mty;
    logic [13:0]  bytes;
  } beat_t;

  logic [511:0] mem [2**ADDR_WIDTH];
  logic [13:0]  len_mem [2**LEN_AW];

  wst_t          wst;
  addr_t         wr_spec;
  addr_t         wr_commit;
  addr_t         rd_ptr;
  addr_t         rd_addr;
  logic [13:0]   wr_bytes;
  logic [LEN_AW:0] len_wr;
  logic [LEN_AW:0] len_rd;
  logic          len_full;
  logic          len_empty;

  assign len_empty = len_wr == len_rd;
  assign len_full  = (len_wr[LEN_AW] != len_rd[LEN_AW]) &&
                     (len_wr[LEN_AW-1:0] == len_rd[LEN_AW-1:0]);

  logic unused_mty;
  assign unused_mty = ^din_mty[7:6];

  logic [6:0]  beat_bytes;
  logic [14:0] new_bytes;
  logic        start;
  logic        cont;
  logic        drop_partial;
  logic        full;
  logic        over;
  logic        abort;
  logic        we;
  logic        commit;
  addr_t       base;

  // A sop always restarts at the committed pointer, rewinding any partial.
  always_comb begin
    beat_bytes   = din_eop ? 7'd64 - {1'b0, din_mty[5:0]} : 7'd64;
    start        = din_valid && din_sop;
    cont         = din_valid && !din_sop && (wst == W_RECV);
    drop_partial = start && (wst == W_RECV);
    base         = start ? wr_commit : wr_spec;
    new_bytes    = (start ? 15'd0 : {1'b0, wr_bytes}) + 15'(beat_bytes);
    full         = (base + addr_t'(1)) == rd_ptr;
    over         = new_bytes > 15'(MAX_BYTES);
    abort        = (start || cont) &&
                   (full || over || (din_eop && (din_err || len_full)));
    we           = (start || cont) && !full && !over;
    commit       = (start || cont) && din_eop && !abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wst        <= W_IDLE;
      wr_spec    <= '0;
      wr_commit  <= '0;
      wr_bytes   <= '0;
      len_wr     <= '0;
      drop_count <= '0;
    end else begin
      drop_count <= drop_count + 32'(drop_partial) + 32'(abort);
      if (abort) begin
        wr_spec <= wr_commit;
        wst     <= din_eop ? W_IDLE : W_DISCARD;
      end else if (commit) begin
        wr_spec   <= base + addr_t'(1);
        wr_commit <= base + addr_t'(1);
        len_wr    <= len_wr + 1'b1;
        wst       <= W_IDLE;
      end else if (we) begin
        wr_spec  <= base + addr_t'(1);
        wr_bytes <= new_bytes[13:0];
        wst      <= W_RECV;
      end else if (din_valid && din_eop && (wst == W_DISCARD)) begin
        wst <= W_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[base] <= din_data;
    if (commit)
      len_mem[len_wr[LEN_AW-1:0]] <= new_bytes[13:0];
  end

  rst_t        rstate;
  logic [13:0] cur_bytes;
  logic [8:0]  cur_beats;
  logic [8:0]  beat_idx;
  logic [13:0] head_bytes;
  logic [8:0]  head_beats;
  logic        last_beat;
  logic        issue;
  logic        pop_len;
  logic        out_pop;
  logic [1:0]  occ;

  logic         r_valid;
  logic         r_sop;
  logic         r_eop;
  logic [7:0]   r_mty;
  logic [13:0]  r_bytes;
  logic [511:0] rdata;
  beat_t        r_beat;
  beat_t        out_q;
  beat_t        skid_q;
  logic         skid_v;

  assign out_pop    = dout_valid && dout_ready;
  assign head_bytes = len_mem[len_rd[LEN_AW-1:0]];
  assign head_beats = 9'((15'(head_bytes) + 15'd63) >> 6);
  assign last_beat  = beat_idx == (cur_beats - 9'd1);
  assign occ        = 2'(dout_valid) + 2'(skid_v) + 2'(r_valid);

  // Reads are issued only when the out/skid pair has room for the
  // beat in flight, so the skid can never overflow.
  assign issue   = (rstate == R_SEND) && ((occ < 2'd2) || out_pop);
  assign pop_len = !len_empty && ((rstate == R_IDLE) || (issue && last_beat));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate    <= R_IDLE;
      len_rd    <= '0;
      rd_addr   <= '0;
      cur_bytes <= '0;
      cur_beats <= '0;
      beat_idx  <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_mty     <= '0;
      r_bytes   <= '0;
    end else begin
      r_valid <= issue;
      if (issue) begin
        rd_addr  <= rd_addr + addr_t'(1);
        beat_idx <= beat_idx + 9'd1;
        r_sop    <= beat_idx == 9'd0;
        r_eop    <= last_beat;
        r_mty    <= last_beat ? {2'b00, 6'd0 - cur_bytes[5:0]} : 8'd0;
        r_bytes  <= cur_bytes;
      end
      if (pop_len) begin
        len_rd    <= len_rd + 1'b1;
        cur_bytes <= head_bytes;
        cur_beats <= head_beats;
        beat_idx  <= '0;
        rstate    <= R_SEND;
      end else if (issue && last_beat) begin
        rstate <= R_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      rdata <= mem[rd_addr];
  end

  assign r_beat = {rdata, r_sop, r_eop, r_mty, r_bytes};

  // rd_ptr frees a slot only once downstream has accepted its beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      skid_q      <= '0;
      skid_v      <= 1'b0;
      dout_valid  <= 1'b0;
      rd_ptr      <= '0;
      frame_count <= '0;
    end else begin
      if (out_pop) begin
        rd_ptr <= rd_ptr + addr_t'(1);
        if (out_q.eop)
          frame_count <= frame_count + 32'd1;
      end
      if (out_pop || !dout_valid) begin
        if (skid_v) begin
          out_q      <= skid_q;
          dout_valid <= 1'b1;
          skid_v     <= r_valid;
          if (r_valid)
            skid_q <= r_beat;
        end else begin
          dout_valid <= r_valid;
          if (r_valid)
            out_q <= r_beat;
        end
      end else if (r_valid) begin
        skid_q <= r_beat;
        skid_v <= 1'b1;
      end
    end
  end

  assign dout_data  = out_q.data;
  assign dout_sop   = out_q.sop;
  assign dout_eop   = out_q.eop;
  assign dout_mty   = out_q.mty;
  assign dout_bytes = out_q.bytes;

endmodule

// File: tb/tb_cmac_usplus_collector.sv
// Directed bench for cmac_usplus_collector with an expected-beat queue
// filled at drive time and drained by a monitor on dout handshakes.
module tb_cmac_usplus_collector;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] din_data = '0;
  logic         din_valid = 1'b0;
  logic         din_sop = 1'b0;
  logic         din_eop = 1'b0;
  logic [7:0]   din_mty = '0;
  logic         din_err = 1'b0;
  logic [511:0] dout_data;
  logic         dout_valid;
  logic         dout_sop;
  logic         dout_eop;
  logic [7:0]   dout_mty;
  logic [13:0]  dout_bytes;
  logic         dout_ready = 1'b1;
  logic [31:0]  frame_count;
  logic [31:0]  drop_count;

  cmac_usplus_collector dut (
    .clk(clk), .reset(reset),
    .din_data(din_data), .din_valid(din_valid),
    .din_sop(din_sop), .din_eop(din_eop),
    .din_mty(din_mty), .din_err(din_err),
    .dout_data(dout_data), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_mty(dout_mty), .dout_bytes(dout_bytes),
    .dout_ready(dout_ready),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [7:0]   mty;
    logic [13:0]  bytes;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_seen = 0;
  int   ready_mode = 1;
  int   exp_frames = 0;
  int   exp_drops = 0;
  int   cyc;
  exp_t mon_got;
  exp_t mon_want;
  logic mon_have;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2)
        dout_ready = 1'($urandom_range(0, 1));
      else
        dout_ready = (ready_mode == 1);
    end
  end

  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      mon_got  = {dout_data, dout_sop, dout_eop, dout_mty, dout_bytes};
      mon_have = q.size() != 0;
      mon_want = mon_have ? q.pop_front() : '0;
      n_chk++;
      n_seen++;
      assert (mon_have && mon_got === mon_want) n_pass++;
      else $error("FAIL beat%0d have=%0d got=%h want=%h",
                  n_seen, mon_have, mon_got, mon_want);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input int bytes, input bit err,
                            input bit do_eop, input bit keep);
    int beats = (bytes + 63) / 64;
    logic [7:0] tail = 8'(beats * 64 - bytes);
    logic [511:0] d;
    exp_t e;
    for (int i = 0; i < beats; i++) begin
      for (int k = 0; k < 16; k++)
        d[k*32 +: 32] = $urandom;
      din_data  = d;
      din_valid = 1'b1;
      din_sop   = (i == 0);
      din_eop   = do_eop && (i == beats - 1);
      din_mty   = din_eop ? (tail | 8'hC0) : 8'hA5;
      din_err   = din_eop ? err : 1'b1;
      if (keep) begin
        e.data  = d;
        e.sop   = (i == 0);
        e.eop   = (i == beats - 1);
        e.mty   = e.eop ? tail : 8'd0;
        e.bytes = 14'(bytes);
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
    din_err   = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (q.size() != 0 && cycles < budget) begin
      @(posedge clk);
      cycles++;
    end
    #1;
    check(tag, 64'(q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frames"}, 64'(frame_count), 64'(exp_frames));
    check({tag, "_drops"}, 64'(drop_count), 64'(exp_drops));
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_data", 64'(|dout_data), 64'd0);
    check("rst_meta", 64'({dout_sop, dout_eop, dout_mty, dout_bytes}), 64'd0);
    check_counts("rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single 60 B beat, latency of three edges after the eop edge
    send_frame(60, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("lat_n1", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_n2", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_n3", 64'(dout_valid), 64'd1);
    exp_frames = 1;
    drain("t1_drain", 50, cyc);
    check_counts("t1");

    // 1514 B frame under random backpressure
    ready_mode = 2;
    send_frame(1514, 1'b0, 1'b1, 1'b1);
    exp_frames++;
    drain("t2_drain", 500, cyc);
    ready_mode = 1;
    check_counts("t2");

    // errored frame dropped, good 64 B frame kept
    send_frame(256, 1'b1, 1'b1, 1'b0);
    send_frame(64, 1'b0, 1'b1, 1'b1);
    exp_frames++;
    exp_drops++;
    drain("t3_drain", 50, cyc);
    check_counts("t3");

    // fill the buffer with 1024 B frames while downstream stalls
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int f = 0; f < 16; f++)
      send_frame(1024, 1'b0, 1'b1, f < 15);
    repeat (4) @(posedge clk);
    #1;
    exp_drops++;
    check_counts("t4_stall");
    ready_mode = 1;
    drain("t4_drain", 600, cyc);
    check("t4_stream", 64'(cyc > 246), 64'd0);
    exp_frames += 15;
    check_counts("t4");

    // partial frame aborted by a new sop
    send_frame(192, 1'b0, 1'b0, 1'b0);
    send_frame(100, 1'b0, 1'b1, 1'b1);
    exp_frames++;
    exp_drops++;
    drain("t5_drain", 50, cyc);
    check_counts("t5");

    // reset in the middle of a 10-beat frame
    begin
      int seen0 = n_seen;
      send_frame(640, 1'b0, 1'b1, 1'b1);
      cyc = 0;
      while (n_seen < seen0 + 4 && cyc < 100) begin
        @(posedge clk);
        cyc++;
      end
      #1;
      check("t6_wait", 64'(n_seen >= seen0 + 4), 64'd1);
    end
    reset = 1'b1;
    #1;
    check("t6_valid", 64'(dout_valid), 64'd0);
    exp_frames = 0;
    exp_drops = 0;
    check_counts("t6_rst");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(64, 1'b0, 1'b1, 1'b1);
    exp_frames = 1;
    drain("t6_drain", 50, cyc);
    check_counts("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
